// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: AXI3 signal bundle between the CPU bridge (master) and the interconnect (slave).
interface cpu_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master(
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave(
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the core's inst/data SRAM-like ports onto one single-beat AXI3 master.
// Define AXI_BRIDGE_RDATA_REG_EN to register *_rdata/*_data_ok one cycle after the AXI beat.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_sram_req,
    input  logic [1:0]       inst_sram_size,
    input  logic [31:0]      inst_sram_addr,
    output logic             inst_sram_addr_ok,
    output logic             inst_sram_data_ok,
    output logic [31:0]      inst_sram_rdata,
    input  logic             data_sram_req,
    input  logic             data_sram_wr,
    input  logic [1:0]       data_sram_size,
    input  logic [3:0]       data_sram_wstrb,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic             data_sram_addr_ok,
    output logic             data_sram_data_ok,
    output logic [31:0]      data_sram_rdata,
    cpu_axi_bridge_if.master axi
);
    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
    ar_state_t ar_state, ar_next;
    w_state_t w_state, w_next;
    logic inst_pend, data_pend, data_rd_win, data_rd_acc, data_wr_acc, ar_acc, r_inst, r_data, unused;

    // A pending data read always wins the AR slot over an inst read in the same cycle.
    assign data_rd_win = data_sram_req & ~data_sram_wr & ~data_pend;
    assign data_rd_acc = data_rd_win & (ar_state == AR_IDLE);
    assign data_wr_acc = data_sram_req & data_sram_wr & ~data_pend & (w_state == W_IDLE);
    assign data_sram_addr_ok = data_rd_acc | data_wr_acc;
    assign inst_sram_addr_ok = inst_sram_req & ~inst_pend & (ar_state == AR_IDLE) & ~data_rd_win;
    assign ar_acc = data_rd_acc | inst_sram_addr_ok;
    assign r_data = axi.rvalid & (axi.rid == DATA_ID);
    assign r_inst = axi.rvalid & (axi.rid != DATA_ID);

    assign axi.arvalid = ar_state == AR_BUSY;
    assign axi.arlen = 4'd0;
    assign axi.arburst = 2'b01;
    assign axi.arlock = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot = 3'd0;
    assign axi.awid = DATA_ID;
    assign axi.awlen = 4'd0;
    assign axi.awburst = 2'b01;
    assign axi.awlock = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot = 3'd0;
    assign axi.wid = DATA_ID;
    assign axi.wlast = 1'b1;
    assign axi.rready = 1'b1;
    assign axi.bready = 1'b1;
    assign unused = &{1'b0, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    always_comb begin
        ar_next = ar_state == AR_IDLE ? (ar_acc ? AR_BUSY : AR_IDLE) : (axi.arready ? AR_IDLE : AR_BUSY);
        w_next = w_state;
        case (w_state)
            W_IDLE:  w_next = data_wr_acc ? W_SEND : W_IDLE;
            W_SEND:  w_next = (~axi.awvalid | axi.awready) & (~axi.wvalid | axi.wready) ? W_RESP : W_SEND;
            default: w_next = axi.bvalid ? W_IDLE : W_RESP;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state <= AR_IDLE;
            w_state <= W_IDLE;
            inst_pend <= 1'b0;
            data_pend <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid <= 1'b0;
        end else begin
            ar_state <= ar_next;
            w_state <= w_next;
            inst_pend <= inst_sram_addr_ok | (inst_pend & ~r_inst);
            data_pend <= data_sram_addr_ok | (data_pend & ~r_data & ~axi.bvalid);
            axi.awvalid <= data_wr_acc | (axi.awvalid & ~axi.awready);
            axi.wvalid <= data_wr_acc | (axi.wvalid & ~axi.wready);
        end
    end

    // Request fields are only observed while their valid is high, so they need no reset.
    always_ff @(posedge clk) begin
        if (ar_acc) begin
            axi.arid <= data_rd_acc ? DATA_ID : INST_ID;
            axi.araddr <= data_rd_acc ? data_sram_addr : inst_sram_addr;
            axi.arsize <= {1'b0, data_rd_acc ? data_sram_size : inst_sram_size};
        end
        if (data_wr_acc) begin
            axi.awaddr <= data_sram_addr;
            axi.awsize <= {1'b0, data_sram_size};
            axi.wdata <= data_sram_wdata;
            axi.wstrb <= data_sram_wstrb;
        end
    end

`ifdef AXI_BRIDGE_RDATA_REG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_data_ok <= 1'b0;
            data_sram_data_ok <= 1'b0;
            inst_sram_rdata <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            inst_sram_data_ok <= r_inst;
            data_sram_data_ok <= r_data | axi.bvalid;
            inst_sram_rdata <= r_inst ? axi.rdata : inst_sram_rdata;
            data_sram_rdata <= r_data ? axi.rdata : data_sram_rdata;
        end
    end
`else
    assign inst_sram_data_ok = r_inst;
    assign data_sram_data_ok = r_data | axi.bvalid;
    assign inst_sram_rdata = axi.rdata;
    assign data_sram_rdata = axi.rdata;
`endif
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed stimulus for cpu_axi_bridge with a transaction-level model checked every cycle.
// Honours AXI_BRIDGE_RDATA_REG_EN to expect registered or combinational data_ok/rdata.
module tb_cpu_axi_bridge;
    localparam logic [3:0] IID = 4'd0;
    localparam logic [3:0] DID = 4'd1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ireq = 1'b0;
    logic [1:0] isize = 2'd0;
    logic [31:0] iaddr = 32'd0;
    logic i_aok, i_dok;
    logic [31:0] i_rdata;
    logic dreq = 1'b0;
    logic dwr = 1'b0;
    logic [1:0] dsize = 2'd0;
    logic [3:0] dstrb = 4'd0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dwdata = 32'd0;
    logic d_aok, d_dok;
    logic [31:0] d_rdata;
    int n_vec = 0;
    int n_err = 0;

    cpu_axi_bridge_if axi();

    cpu_axi_bridge #(.INST_ID(IID), .DATA_ID(DID)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(ireq), .inst_sram_size(isize), .inst_sram_addr(iaddr),
        .inst_sram_addr_ok(i_aok), .inst_sram_data_ok(i_dok), .inst_sram_rdata(i_rdata),
        .data_sram_req(dreq), .data_sram_wr(dwr), .data_sram_size(dsize), .data_sram_wstrb(dstrb),
        .data_sram_addr(daddr), .data_sram_wdata(dwdata),
        .data_sram_addr_ok(d_aok), .data_sram_data_ok(d_dok), .data_sram_rdata(d_rdata),
        .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: outstanding work per port and per AXI channel.
    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;
    ar_t ar_q[$];
    bit m_ibusy, m_dbusy, m_wbusy, m_aw, m_w;
    logic [31:0] m_awaddr, m_wdata;
    logic [2:0] m_awsize;
    logic [3:0] m_wstrb;
    bit p_iok, p_dok;
    logic [31:0] p_ird = 32'd0;
    logic [31:0] p_drd = 32'd0;
    bit e_iaok, e_daok, e_iok, e_dok, e_rd, d_rd;

    always @(negedge clk) begin
        if (!resetn) begin
            ar_q.delete();
            {m_ibusy, m_dbusy, m_wbusy, m_aw, m_w, p_iok, p_dok} = '0;
            p_ird = 32'd0;
            p_drd = 32'd0;
        end
        d_rd = dreq && !dwr && !m_dbusy;
        e_daok = dreq && !m_dbusy && (dwr ? !m_wbusy : ar_q.size() == 0);
        e_iaok = ireq && !m_ibusy && ar_q.size() == 0 && !d_rd;
        e_rd = axi.rvalid && axi.rid == DID;
        e_iok = axi.rvalid && axi.rid != DID;
        e_dok = e_rd || axi.bvalid;
        chk("inst_addr_ok", i_aok, e_iaok);
        chk("data_addr_ok", d_aok, e_daok);
        chk("arvalid", axi.arvalid, ar_q.size() != 0);
        if (ar_q.size() != 0) begin
            chk("arid", axi.arid, ar_q[0].id);
            chk("araddr", axi.araddr, ar_q[0].addr);
            chk("arsize", axi.arsize, ar_q[0].size);
        end
        chk("awvalid", axi.awvalid, m_aw);
        chk("wvalid", axi.wvalid, m_w);
        if (m_aw) begin
            chk("awaddr", axi.awaddr, m_awaddr);
            chk("awsize", axi.awsize, m_awsize);
        end
        if (m_w) begin
            chk("wdata", axi.wdata, m_wdata);
            chk("wstrb", axi.wstrb, m_wstrb);
        end
        chk("rready", axi.rready, 1);
        chk("bready", axi.bready, 1);
`ifdef AXI_BRIDGE_RDATA_REG_EN
        chk("inst_data_ok", i_dok, p_iok);
        chk("data_data_ok", d_dok, p_dok);
        chk("inst_rdata", i_rdata, p_ird);
        chk("data_rdata", d_rdata, p_drd);
`else
        chk("inst_data_ok", i_dok, e_iok);
        chk("data_data_ok", d_dok, e_dok);
        if (e_iok) chk("inst_rdata", i_rdata, axi.rdata);
        if (e_rd) chk("data_rdata", d_rdata, axi.rdata);
`endif
        if (resetn) begin
            p_iok = e_iok;
            p_dok = e_dok;
            if (e_iok) p_ird = axi.rdata;
            if (e_rd) p_drd = axi.rdata;
            if (ar_q.size() != 0 && axi.arready) void'(ar_q.pop_front());
            if (axi.awready) m_aw = 0;
            if (axi.wready) m_w = 0;
            if (e_iok) m_ibusy = 0;
            if (e_rd) m_dbusy = 0;
            if (axi.bvalid) {m_dbusy, m_wbusy} = 2'b00;
            if (e_daok && dwr) begin
                {m_dbusy, m_wbusy, m_aw, m_w} = 4'hf;
                m_awaddr = daddr;
                m_awsize = {1'b0, dsize};
                m_wdata = dwdata;
                m_wstrb = dstrb;
            end else if (e_daok) begin
                m_dbusy = 1;
                ar_q.push_back(ar_t'{DID, daddr, {1'b0, dsize}});
            end
            if (e_iaok) begin
                m_ibusy = 1;
                ar_q.push_back(ar_t'{IID, iaddr, {1'b0, isize}});
            end
        end
    end

    task automatic lit_ok(input logic [3:0] id, input logic [31:0] data);
        if (id == DID) begin
            chk("lit data_ok", d_dok, 1);
            chk("lit data rdata", d_rdata, data);
        end else begin
            chk("lit inst_ok", i_dok, 1);
            chk("lit inst rdata", i_rdata, data);
        end
    endtask

    task automatic rbeat(input logic [3:0] id, input logic [31:0] data);
        axi.rvalid = 1'b1;
        axi.rid = id;
        axi.rdata = data;
        #1;
`ifndef AXI_BRIDGE_RDATA_REG_EN
        lit_ok(id, data);
`endif
        cyc();
        axi.rvalid = 1'b0;
        axi.rdata = 32'd0;
        #1;
`ifdef AXI_BRIDGE_RDATA_REG_EN
        lit_ok(id, data);
`endif
    endtask

    task automatic bbeat();
        axi.bvalid = 1'b1;
        #1;
`ifndef AXI_BRIDGE_RDATA_REG_EN
        chk("lit b data_ok", d_dok, 1);
`endif
        chk("lit b no early accept", d_aok, 0);
        cyc();
        axi.bvalid = 1'b0;
        #1;
`ifdef AXI_BRIDGE_RDATA_REG_EN
        chk("lit b data_ok", d_dok, 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        {axi.arready, axi.rvalid, axi.rlast, axi.awready, axi.wready, axi.bvalid} = '0;
        axi.rid = 4'd0;
        axi.rdata = 32'd0;
        axi.rresp = 2'd0;
        axi.bid = DID;
        axi.bresp = 2'd0;
        #3;
        chk("rst arvalid", axi.arvalid, 0);
        chk("rst awvalid", axi.awvalid, 0);
        chk("rst wvalid", axi.wvalid, 0);
        chk("rst inst_data_ok", i_dok, 0);
        chk("rst data_data_ok", d_dok, 0);
        chk("rst inst_rdata", i_rdata, 0);
        chk("rst data_rdata", d_rdata, 0);
        chk("rst rready", axi.rready, 1);
        chk("rst bready", axi.bready, 1);
        chk("const arlen", axi.arlen, 0);
        chk("const arburst", axi.arburst, 1);
        chk("const awburst", axi.awburst, 1);
        chk("const wlast", axi.wlast, 1);
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        // Single inst read.
        ireq = 1; isize = 2; iaddr = 32'h1c000000; axi.arready = 1; #1;
        chk("t1 inst addr_ok", i_aok, 1);
        cyc();
        ireq = 0; #1;
        chk("t1 arvalid", axi.arvalid, 1);
        chk("t1 arid", axi.arid, 0);
        chk("t1 araddr", axi.araddr, 32'h1c000000);
        chk("t1 arsize", axi.arsize, 2);
        cyc();
        chk("t1 arvalid drop", axi.arvalid, 0);
        cyc();
        rbeat(IID, 32'h02c00000);
        // Same-cycle inst and data reads.
        ireq = 1; iaddr = 32'h1c000100; isize = 2;
        dreq = 1; dwr = 0; daddr = 32'h200; dsize = 2; axi.arready = 0; #1;
        chk("t2 data addr_ok", d_aok, 1);
        chk("t2 inst blocked", i_aok, 0);
        cyc();
        dreq = 0; axi.arready = 1; #1;
        chk("t2 arid data", axi.arid, DID);
        chk("t2 inst wait", i_aok, 0);
        cyc();
        chk("t2 inst accepted", i_aok, 1);
        cyc();
        ireq = 0; #1;
        chk("t2 arid inst", axi.arid, IID);
        chk("t2 araddr inst", axi.araddr, 32'h1c000100);
        cyc();
        axi.arready = 0;
        rbeat(DID, 32'hdeadbeef);
        rbeat(IID, 32'h0badf00d);
        // AR stall: fields stable, no new accepts.
        dreq = 1; dwr = 0; daddr = 32'h400; dsize = 1; #1;
        chk("t4 data addr_ok", d_aok, 1);
        cyc();
        ireq = 1; iaddr = 32'h500; isize = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4 arvalid held", axi.arvalid, 1);
            chk("t4 araddr held", axi.araddr, 32'h400);
            chk("t4 arid held", axi.arid, DID);
            chk("t4 no inst accept", i_aok, 0);
            chk("t4 no data accept", d_aok, 0);
            cyc();
        end
        axi.arready = 1;
        cyc();
        chk("t4 inst after stall", i_aok, 1);
        cyc();
        ireq = 0; dreq = 0; #1;
        chk("t4 inst araddr", axi.araddr, 32'h500);
        chk("t4 inst arsize", axi.arsize, 0);
        cyc();
        axi.arready = 0;
        rbeat(IID, 32'h11112222);
        rbeat(DID, 32'h33334444);
        // Write with awready three cycles ahead of wready.
        dreq = 1; dwr = 1; daddr = 32'h80; dsize = 2; dstrb = 4'b0011; dwdata = 32'h1234abcd; #1;
        chk("t3 write addr_ok", d_aok, 1);
        cyc();
        dreq = 0; dwr = 0; axi.awready = 1; #1;
        chk("t3 awvalid", axi.awvalid, 1);
        chk("t3 wvalid", axi.wvalid, 1);
        chk("t3 awaddr", axi.awaddr, 32'h80);
        chk("t3 wstrb", axi.wstrb, 4'b0011);
        chk("t3 wdata", axi.wdata, 32'h1234abcd);
        chk("t3 awid", axi.awid, DID);
        cyc();
        axi.awready = 0; #1;
        chk("t3 awvalid drop", axi.awvalid, 0);
        chk("t3 wvalid hold", axi.wvalid, 1);
        cyc();
        cyc();
        axi.wready = 1;
        cyc();
        axi.wready = 0; #1;
        chk("t3 wvalid drop", axi.wvalid, 0);
        dreq = 1; dwr = 1; daddr = 32'h84; dstrb = 4'hf; dwdata = 32'h55aa55aa; #1;
        chk("t3 second write waits", d_aok, 0);
        cyc();
        chk("t3 second write still waits", d_aok, 0);
        bbeat();
        chk("t3 second write accepted", d_aok, 1);
        cyc();
        dreq = 0; dwr = 0; axi.awready = 1; axi.wready = 1; #1;
        chk("t3 awaddr 2", axi.awaddr, 32'h84);
        chk("t3 wdata 2", axi.wdata, 32'h55aa55aa);
        cyc();
        axi.awready = 0; axi.wready = 0; #1;
        chk("t3 both dropped", {axi.awvalid, axi.wvalid}, 0);
        cyc();
        bbeat();
        // Reset while W is sending.
        dreq = 1; dwr = 1; daddr = 32'hc0; dstrb = 4'hf; dwdata = 32'hcafe0001; #1;
        chk("t5 write addr_ok", d_aok, 1);
        cyc();
        dreq = 0; dwr = 0; #1;
        chk("t5 awvalid before rst", axi.awvalid, 1);
        resetn = 0; #1;
        chk("t5 async awvalid", axi.awvalid, 0);
        chk("t5 async wvalid", axi.wvalid, 0);
        cyc();
        cyc();
        resetn = 1;
        dreq = 1; dwr = 1; daddr = 32'h100; dwdata = 32'h0000beef; axi.awready = 1; axi.wready = 1; #1;
        chk("t5 accept after rst", d_aok, 1);
        cyc();
        dreq = 0; dwr = 0; #1;
        chk("t5 awaddr after rst", axi.awaddr, 32'h100);
        cyc();
        axi.awready = 0; axi.wready = 0;
        cyc();
        bbeat();
        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
